srl_tap_reader: RTL and testbench

- Sequencer on the far side of the 128x18 addressable shift-register delay line used by the FIR filters. It accepts input samples on a strobe, pushes each sample into the external delay line through the line's d/ce port, then sweeps the line's address from newest (0) to oldest (ntap).
- Each stored tap is presented to the downstream MAC with index, first and last flags.
- It buffers one pending sample while a sweep is in progress and flags overruns.

---
 rtl/srl_tap_reader.sv | 147 ++++++++++++++
 tb/tb_srl_tap_reader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/srl_tap_reader.sv
// srl_tap_reader
// Sequencer in front of an external addressable shift-register delay line.
// Input samples arrive on a strobe and wait in a one-deep hold register. From
// IDLE a held sample is shifted into the line, and then the line is swept from
// the newest tap (address 0) to the oldest (ntap). Each tap is presented on a
// registered output together with its index and first/last flags.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   in_d, in_stb     input sample and its one-cycle strobe
//   ntap             number of taps minus 1, latched at sweep start
//   srl_d, srl_ce    data and shift enable to the delay line
//   srl_a, srl_y     read address to the line; combinational read data back
//   out_d, out_idx   registered tap sample and its index (0 = newest)
//   out_vld          out_d/out_idx/out_first/out_last are valid
//   out_first        tap index 0
//   out_last         tap index equal to the latched ntap
//   busy             a sweep is in progress
//   ovr              one-cycle pulse when an input sample was dropped
module srl_tap_reader #(
    parameter int unsigned W  = 18,
    parameter int unsigned AW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  in_d,
    input  logic          in_stb,
    input  logic [AW-1:0] ntap,
    output logic [W-1:0]  srl_d,
    output logic          srl_ce,
    output logic [AW-1:0] srl_a,
    input  logic [W-1:0]  srl_y,
    output logic [W-1:0]  out_d,
    output logic [AW-1:0] out_idx,
    output logic          out_vld,
    output logic          out_first,
    output logic          out_last,
    output logic          busy,
    output logic          ovr
);

    typedef enum logic {
        S_IDLE,
        S_SWEEP
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] ntap_l_q, ntap_l_d;
    logic          ovr_q, ovr_d;
    logic          consume;

    logic [W-1:0]  out_d_q;
    logic [AW-1:0] out_idx_q;
    logic          out_vld_q, out_first_q, out_last_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        ntap_l_d    = ntap_l_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        ovr_d       = 1'b0;
        consume     = 1'b0;
        srl_ce      = 1'b0;
        srl_a       = '0;

        case (state_q)
            S_IDLE: begin
                if (hold_full_q) begin
                    consume  = 1'b1;
                    // The line has no reset; never shift it during a reset cycle.
                    srl_ce   = ~rst;
                    ntap_l_d = ntap;
                    addr_d   = '0;
                    state_d  = S_SWEEP;
                end
            end
            S_SWEEP: begin
                srl_a  = addr_q;
                addr_d = addr_q + 1'b1;
                if (addr_q == ntap_l_q) begin
                    addr_d  = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end
        endcase

        // A sample leaving the hold register this cycle frees the slot for a
        // simultaneous capture, so that case is not an overrun.
        if (consume) begin
            hold_full_d = 1'b0;
        end
        if (in_stb) begin
            if (!hold_full_q || consume) begin
                hold_d      = in_d;
                hold_full_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            addr_q      <= '0;
            ntap_l_q    <= '0;
            ovr_q       <= 1'b0;
            out_d_q     <= '0;
            out_idx_q   <= '0;
            out_vld_q   <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            addr_q      <= addr_d;
            ntap_l_q    <= ntap_l_d;
            ovr_q       <= ovr_d;
            out_d_q     <= srl_y;
            out_idx_q   <= addr_q;
            out_vld_q   <= (state_q == S_SWEEP);
            out_first_q <= (state_q == S_SWEEP) && (addr_q == '0);
            out_last_q  <= (state_q == S_SWEEP) && (addr_q == ntap_l_q);
        end
    end

    assign srl_d     = hold_q;
    assign busy      = (state_q == S_SWEEP);
    assign ovr       = ovr_q;
    assign out_d     = out_d_q;
    assign out_idx   = out_idx_q;
    assign out_vld   = out_vld_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_srl_tap_reader.sv
// Testbench for srl_tap_reader: drives directed and random strobe patterns
// against a behavioural delay line, and predicts every output from a
// transaction-level model (pending sample, remaining sweep length, history
// queue of samples pushed into the line).
module tb_srl_tap_reader;

    localparam int unsigned W     = 18;
    localparam int unsigned AW    = 7;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  in_d = '0;
    logic          in_stb = 1'b0;
    logic [AW-1:0] ntap = '0;
    logic [W-1:0]  srl_d;
    logic          srl_ce;
    logic [AW-1:0] srl_a;
    logic [W-1:0]  srl_y;
    logic [W-1:0]  out_d;
    logic [AW-1:0] out_idx;
    logic          out_vld, out_first, out_last, busy, ovr;

    always #5 clk = ~clk;

    srl_tap_reader #(.W(W), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_d      (in_d),
        .in_stb    (in_stb),
        .ntap      (ntap),
        .srl_d     (srl_d),
        .srl_ce    (srl_ce),
        .srl_a     (srl_a),
        .srl_y     (srl_y),
        .out_d     (out_d),
        .out_idx   (out_idx),
        .out_vld   (out_vld),
        .out_first (out_first),
        .out_last  (out_last),
        .busy      (busy),
        .ovr       (ovr)
    );

    // External delay line: no reset, starts at zero.
    logic [W-1:0] line_mem [DEPTH];
    initial begin
        for (int i = 0; i < int'(DEPTH); i++) line_mem[i] = '0;
    end
    always @(posedge clk) begin
        if (srl_ce) begin
            for (int i = int'(DEPTH) - 1; i > 0; i--) line_mem[i] <= line_mem[i-1];
            line_mem[0] <= srl_d;
        end
    end
    assign srl_y = line_mem[srl_a];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model
    bit           armed = 1'b0;
    bit           m_pend = 1'b0;
    logic [W-1:0] m_pval = '0;
    int           m_left = 0;
    int           m_pos = 0;
    int           m_n = 0;
    logic [W-1:0] m_hist [$];
    int unsigned  m_firsts = 0;
    int unsigned  d_firsts = 0;
    logic [W-1:0] e_d = '0;
    int           e_idx = 0;
    bit           e_vld = 0, e_first = 0, e_last = 0, e_ovr = 0;

    task automatic model_step(input bit stb, input logic [W-1:0] d);
        bit consume;
        if (rst) begin
            m_pend = 0; m_left = 0; m_pos = 0;
            e_d = '0; e_idx = 0; e_vld = 0; e_first = 0; e_last = 0; e_ovr = 0;
            armed = 1'b1;
        end else begin
            consume = (m_left == 0) && m_pend;
            e_vld   = (m_left > 0);
            e_idx   = e_vld ? m_pos : 0;
            e_first = e_vld && (m_pos == 0);
            e_last  = e_vld && (m_pos == m_n);
            e_d     = e_vld ? m_hist[m_pos] : '0;
            if (e_vld && e_first) m_firsts++;
            if (m_left > 0) begin
                m_left--;
                m_pos++;
            end else if (m_pend) begin
                m_hist.push_front(m_pval);
                if (m_hist.size() > int'(DEPTH)) void'(m_hist.pop_back());
                m_left = int'(ntap) + 1;
                m_pos  = 0;
                m_n    = int'(ntap);
            end
            e_ovr = 0;
            if (stb) begin
                if (!m_pend || consume) begin
                    m_pend = 1;
                    m_pval = d;
                end else begin
                    e_ovr = 1;
                end
            end else if (consume) begin
                m_pend = 0;
            end
        end
    endtask

    task automatic cycle(input bit stb, input logic [W-1:0] d);
        bit exp_ce;
        in_stb = stb;
        in_d   = d;
        #1;
        if (armed) begin
            exp_ce = !rst && (m_left == 0) && m_pend;
            chk("busy", 32'(busy), 32'(m_left > 0));
            chk("srl_ce", 32'(srl_ce), 32'(exp_ce));
            chk("srl_a", 32'(srl_a), (m_left > 0) ? 32'(m_pos) : 32'd0);
            if (exp_ce) chk("srl_d", 32'(srl_d), 32'(m_pval));
        end
        @(posedge clk);
        model_step(stb, d);
        #1;
        if (armed) begin
            chk("out_vld", 32'(out_vld), 32'(e_vld));
            chk("out_idx", 32'(out_idx), 32'(e_idx));
            chk("out_first", 32'(out_first), 32'(e_first));
            chk("out_last", 32'(out_last), 32'(e_last));
            chk("ovr", 32'(ovr), 32'(e_ovr));
            if (e_vld) chk("out_d", 32'(out_d), 32'(e_d));
            if (out_vld && out_first) d_firsts++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0);
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) m_hist.push_back('0);

        // Reset and check the reset state
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vld", 32'(out_vld), 32'd0);

        // Four strobes, ntap=3
        ntap = 7'd3;
        for (int s = 1; s <= 4; s++) begin
            cycle(1'b1, W'(s));
            idle(9);
        end

        // Single-tap sweep
        ntap = 7'd0;
        cycle(1'b1, 18'h2AAAA);
        idle(6);

        // Held second sample, then a dropped third sample
        ntap = 7'd7;
        cycle(1'b1, 18'h00100); idle(1);
        cycle(1'b1, 18'h00200); idle(25);
        cycle(1'b1, 18'h00300); idle(1);
        cycle(1'b1, 18'h00400); idle(1);
        cycle(1'b1, 18'h00500); idle(25);

        // Random traffic: ntap changes mid-sweep, bursts, occasional resets
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 9))
                    0:       ntap = '0;
                    1:       ntap = '1;
                    default: ntap = AW'($urandom_range(0, 12));
                endcase
            end
            rst = ($urandom_range(0, 499) == 0);
            cycle($urandom_range(0, 7) == 0, W'($urandom));
        end
        rst = 1'b0;
        idle(140);

        // Full-depth sweeps with ascending data
        ntap = '1;
        for (int s = 0; s < 130; s++) begin
            cycle(1'b1, W'(18'h01000 + s));
            idle(129);
        end
        idle(5);

        // Reset at sweep cycle 2 with a pending sample
        ntap = 7'd15;
        cycle(1'b1, 18'h3F0F0);
        cycle(1'b1, 18'h0F0F0);
        idle(2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(20);
        cycle(1'b1, 18'h12345);
        idle(25);

        chk("sweeps_seen", 32'(d_firsts), 32'(m_firsts));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
